// File: rtl/upsp_pkg.sv
// Shared types and constants for the up-sampling frame sequencer.
package upsp_pkg;

  // Frame sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } upsp_state_e;

  // UPSTR control register bit positions
  localparam int START_BIT = 0;
  localparam int ABORT_BIT = 1;

  // UPENDR status register bit positions
  localparam int DONE_BIT    = 0;
  localparam int BUSY_BIT    = 1;
  localparam int ERR_BIT     = 2;
  localparam int ABORTED_BIT = 3;

  // Default frame geometry
  localparam int DEF_CRF_DATA_WIDTH  = 32;
  localparam int DEF_UPSP_DATA_WIDTH = 24;
  localparam int DEF_SRC_WIDTH       = 960;
  localparam int DEF_SRC_HEIGHT      = 540;
  localparam int DEF_SCALE           = 4;

endpackage

// File: rtl/upsp_beat_cnt.sv
// Saturating beat counter with a terminal-beat flag (count == TERM-1).
module upsp_beat_cnt #(
  parameter int TERM = 8,
  parameter int CW   = $clog2(TERM + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] count,
  output logic          last
);

  // Count accepted beats; clear wins over increment, and the count holds at TERM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != CW'(TERM))) begin
      count <= count + CW'(1);
    end
  end

  assign last = (count == CW'(TERM - 1));

endmodule

// File: rtl/upsp_frame_ctrl.sv
// Frame sequencer: opens/closes the source and result streams around one frame
// and reports DONE/BUSY/ERR/ABORTED through UPENDR.
import upsp_pkg::*;

module upsp_frame_ctrl #(
  parameter int CRF_DATA_WIDTH  = DEF_CRF_DATA_WIDTH,
  parameter int UPSP_DATA_WIDTH = DEF_UPSP_DATA_WIDTH,
  parameter int SRC_WIDTH       = DEF_SRC_WIDTH,
  parameter int SRC_HEIGHT      = DEF_SRC_HEIGHT,
  parameter int SCALE           = DEF_SCALE
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       crf_upstr_we,
  input  logic [CRF_DATA_WIDTH-1:0]  crf_upstr,
  output logic [CRF_DATA_WIDTH-1:0]  upendr,
  input  logic                       ac_upsp_rvalid,
  input  logic [UPSP_DATA_WIDTH-1:0] ac_upsp_rdata,
  output logic                       upsp_ac_rready,
  output logic                       core_rvalid,
  output logic [UPSP_DATA_WIDTH-1:0] core_rdata,
  input  logic                       core_rready,
  input  logic                       core_wvalid,
  input  logic [UPSP_DATA_WIDTH-1:0] core_wdata,
  output logic                       core_wready,
  output logic                       upsp_ac_wvalid,
  output logic [UPSP_DATA_WIDTH-1:0] upsp_ac_wdata,
  input  logic                       ac_upsp_wready
);

  localparam int RD_TOTAL = SRC_WIDTH * SRC_HEIGHT;
  localparam int WR_TOTAL = RD_TOTAL * SCALE * SCALE;
  localparam int RD_CW    = $clog2(RD_TOTAL + 1);
  localparam int WR_CW    = $clog2(WR_TOTAL + 1);

  upsp_state_e r_state;
  upsp_state_e w_state_nxt;
  logic        r_done, r_err, r_aborted;
  logic        w_done_nxt, w_err_nxt, w_aborted_nxt;
  logic        r_rd_open, r_wr_open;
  logic        w_cnt_clr;

  logic             w_start, w_abort;
  logic             w_rd_beat, w_wr_beat;
  logic             w_rd_last, w_wr_last;
  logic             w_rd_done, w_wr_done;
  logic [RD_CW-1:0] w_rd_count;
  logic [WR_CW-1:0] w_wr_count;
  logic             w_unused;

  // ABORT takes priority: a write carrying both bits is treated as an abort only
  assign w_abort = crf_upstr_we & crf_upstr[ABORT_BIT];
  assign w_start = crf_upstr_we & crf_upstr[START_BIT] & ~crf_upstr[ABORT_BIT];

  // Stream gating: pure AND with the registered open flags, data passes straight through
  assign upsp_ac_rready = core_rready    & r_rd_open;
  assign core_rvalid    = ac_upsp_rvalid & r_rd_open;
  assign core_wready    = ac_upsp_wready & r_wr_open;
  assign upsp_ac_wvalid = core_wvalid    & r_wr_open;
  assign core_rdata     = ac_upsp_rdata;
  assign upsp_ac_wdata  = core_wdata;

  assign w_rd_beat = ac_upsp_rvalid & upsp_ac_rready;
  assign w_wr_beat = upsp_ac_wvalid & ac_upsp_wready;
  assign w_rd_done = w_rd_beat & w_rd_last;
  assign w_wr_done = w_wr_beat & w_wr_last;

  upsp_beat_cnt #(.TERM(RD_TOTAL), .CW(RD_CW)) u_rd_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_cnt_clr),
    .inc   (w_rd_beat),
    .count (w_rd_count),
    .last  (w_rd_last)
  );

  upsp_beat_cnt #(.TERM(WR_TOTAL), .CW(WR_CW)) u_wr_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_cnt_clr),
    .inc   (w_wr_beat),
    .count (w_wr_count),
    .last  (w_wr_last)
  );

  // Next-state, sticky status flags and counter clear for the frame sequencer
  always_comb begin
    w_state_nxt   = r_state;
    w_done_nxt    = r_done;
    w_err_nxt     = r_err;
    w_aborted_nxt = r_aborted;
    w_cnt_clr     = 1'b0;
    if (w_abort) begin
      w_state_nxt   = IDLE;
      w_aborted_nxt = 1'b1;
      w_cnt_clr     = 1'b1;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_start) begin
            w_state_nxt   = RUN;
            w_done_nxt    = 1'b0;
            w_err_nxt     = 1'b0;
            w_aborted_nxt = 1'b0;
            w_cnt_clr     = 1'b1;
          end
        end
        RUN: begin
          if (w_wr_done) begin
            // Output complete: clean only if the source finished in the same cycle
            w_state_nxt = IDLE;
            if (w_rd_done) w_done_nxt = 1'b1;
            else           w_err_nxt  = 1'b1;
          end else if (w_rd_done) begin
            w_state_nxt = DRAIN;
          end
        end
        DRAIN: begin
          if (w_wr_done) begin
            w_state_nxt = IDLE;
            w_done_nxt  = 1'b1;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // State, status and stream-open registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_aborted <= 1'b0;
      r_rd_open <= 1'b0;
      r_wr_open <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_done    <= w_done_nxt;
      r_err     <= w_err_nxt;
      r_aborted <= w_aborted_nxt;
      r_rd_open <= (w_state_nxt == RUN);
      r_wr_open <= (w_state_nxt != IDLE);
    end
  end

  // Status register image
  always_comb begin
    upendr              = '0;
    upendr[DONE_BIT]    = r_done;
    upendr[BUSY_BIT]    = (r_state != IDLE);
    upendr[ERR_BIT]     = r_err;
    upendr[ABORTED_BIT] = r_aborted;
  end

  // Reserved UPSTR bits and the raw counts are intentionally not consumed
  assign w_unused = &{1'b0, crf_upstr[CRF_DATA_WIDTH-1:2], w_rd_count, w_wr_count};

endmodule

// File: tb/tb_upsp_frame_ctrl.sv
// Randomized bench for upsp_frame_ctrl with a frame-level reference model.
module tb_upsp_frame_ctrl;

  localparam int CW   = 32;
  localparam int DW   = 24;
  localparam int SW   = 4;
  localparam int SH   = 2;
  localparam int SC   = 2;
  localparam int RD_N = SW * SH;
  localparam int WR_N = RD_N * SC * SC;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          crf_upstr_we;
  logic [CW-1:0] crf_upstr;
  logic [CW-1:0] upendr;
  logic          ac_upsp_rvalid;
  logic [DW-1:0] ac_upsp_rdata;
  logic          upsp_ac_rready;
  logic          core_rvalid;
  logic [DW-1:0] core_rdata;
  logic          core_rready;
  logic          core_wvalid;
  logic [DW-1:0] core_wdata;
  logic          core_wready;
  logic          upsp_ac_wvalid;
  logic [DW-1:0] upsp_ac_wdata;
  logic          ac_upsp_wready;

  always #5 clk = ~clk;

  upsp_frame_ctrl #(
    .CRF_DATA_WIDTH (CW),
    .UPSP_DATA_WIDTH(DW),
    .SRC_WIDTH      (SW),
    .SRC_HEIGHT     (SH),
    .SCALE          (SC)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .crf_upstr_we  (crf_upstr_we),
    .crf_upstr     (crf_upstr),
    .upendr        (upendr),
    .ac_upsp_rvalid(ac_upsp_rvalid),
    .ac_upsp_rdata (ac_upsp_rdata),
    .upsp_ac_rready(upsp_ac_rready),
    .core_rvalid   (core_rvalid),
    .core_rdata    (core_rdata),
    .core_rready   (core_rready),
    .core_wvalid   (core_wvalid),
    .core_wdata    (core_wdata),
    .core_wready   (core_wready),
    .upsp_ac_wvalid(upsp_ac_wvalid),
    .upsp_ac_wdata (upsp_ac_wdata),
    .ac_upsp_wready(ac_upsp_wready)
  );

  int n_checks = 0;
  int n_bad    = 0;

  // Frame-level reference model
  bit m_active, m_done, m_err, m_aborted;
  int m_reads, m_writes;

  // Environment: source, core and sink behaviour
  int          stall_pct;
  int          rd_limit;
  bit          ratio_en;
  int          src_idx, core_rx_cnt, core_tx_idx;
  int unsigned rbase, wbase;
  logic [DW-1:0] rx_q[$];
  logic [DW-1:0] wx_q[$];

  function automatic logic [CW-1:0] exp_upendr();
    logic [CW-1:0] v;
    v    = '0;
    v[0] = m_done;
    v[1] = m_active;
    v[2] = m_err;
    v[3] = m_aborted;
    return v;
  endfunction

  function automatic bit rnd_go();
    return ($urandom_range(99) >= stall_pct);
  endfunction

  task automatic setup_env(input int stall, input int lim, input bit ratio);
    stall_pct   = stall;
    rd_limit    = lim;
    ratio_en    = ratio;
    src_idx     = 0;
    core_rx_cnt = 0;
    core_tx_idx = 0;
    rbase       = $urandom;
    wbase       = $urandom;
    rx_q.delete();
    wx_q.delete();
  endtask

  // One clock cycle: drive on negedge, check, update environment and model
  task automatic cycle(input bit we, input logic [CW-1:0] wd);
    bit exp_ro, exp_wo, rhs, whs, st, ab;
    @(negedge clk);
    crf_upstr_we   = we;
    crf_upstr      = wd;
    ac_upsp_rvalid = rnd_go();
    ac_upsp_rdata  = DW'(rbase + src_idx);
    core_rready    = (core_rx_cnt < rd_limit) && rnd_go();
    core_wvalid    = (!ratio_en || (core_tx_idx < SC * SC * core_rx_cnt)) && rnd_go();
    core_wdata     = DW'(wbase + core_tx_idx);
    ac_upsp_wready = rnd_go();
    #1;
    exp_ro = m_active && (m_reads < RD_N);
    exp_wo = m_active;
    n_checks++;
    if (upendr !== exp_upendr()) begin
      n_bad++;
      $display("FAIL upendr got=%h exp=%h t=%0t", upendr, exp_upendr(), $time);
    end
    n_checks++;
    if ({upsp_ac_rready, core_rvalid, core_wready, upsp_ac_wvalid} !==
        {core_rready & exp_ro, ac_upsp_rvalid & exp_ro, ac_upsp_wready & exp_wo, core_wvalid & exp_wo}) begin
      n_bad++;
      $display("FAIL gates got=%b exp=%b t=%0t",
               {upsp_ac_rready, core_rvalid, core_wready, upsp_ac_wvalid},
               {core_rready & exp_ro, ac_upsp_rvalid & exp_ro, ac_upsp_wready & exp_wo, core_wvalid & exp_wo}, $time);
    end
    if (ac_upsp_rvalid && upsp_ac_rready) src_idx++;
    if (core_rvalid && core_rready) begin rx_q.push_back(core_rdata); core_rx_cnt++; end
    if (core_wvalid && core_wready) core_tx_idx++;
    if (upsp_ac_wvalid && ac_upsp_wready) wx_q.push_back(upsp_ac_wdata);
    rhs = ac_upsp_rvalid & core_rready & exp_ro;
    whs = core_wvalid & ac_upsp_wready & exp_wo;
    st  = we & wd[0] & ~wd[1];
    ab  = we & wd[1];
    if (ab) begin
      m_active = 0; m_aborted = 1; m_reads = 0; m_writes = 0;
    end else if (st && !m_active) begin
      m_active = 1; m_done = 0; m_err = 0; m_aborted = 0; m_reads = 0; m_writes = 0;
    end else if (m_active) begin
      m_reads  += int'(rhs);
      m_writes += int'(whs);
      if (m_writes == WR_N) begin
        m_active = 0;
        if (m_reads == RD_N) m_done = 1;
        else                 m_err  = 1;
      end
    end
  endtask

  // Start a frame and run until the model says it has finished (or abort point)
  task automatic run_frame(input string name, input int abort_at);
    int c;
    cycle(1'b1, 32'h1);
    for (c = 0; c < 600; c++) begin
      if (!m_active) break;
      if (abort_at >= 0 && m_writes >= abort_at) begin
        cycle(1'b1, 32'h2);
        break;
      end
      cycle(1'b0, '0);
    end
    n_checks++;
    if (m_active) begin
      n_bad++;
      $display("FAIL %s timeout reads=%0d writes=%0d", name, m_reads, m_writes);
    end
    cycle(1'b0, '0);
  endtask

  task automatic check_data(input string name, input int exp_rd, input int exp_wr);
    n_checks++;
    if (exp_rd >= 0 && rx_q.size() != exp_rd) begin
      n_bad++;
      $display("FAIL %s read_count got=%0d exp=%0d", name, rx_q.size(), exp_rd);
    end
    n_checks++;
    if (exp_wr >= 0 && wx_q.size() != exp_wr) begin
      n_bad++;
      $display("FAIL %s write_count got=%0d exp=%0d", name, wx_q.size(), exp_wr);
    end
    for (int i = 0; i < rx_q.size(); i++) begin
      n_checks++;
      if (rx_q[i] !== DW'(rbase + i)) begin
        n_bad++;
        $display("FAIL %s rdata[%0d] got=%h exp=%h", name, i, rx_q[i], DW'(rbase + i));
      end
    end
    for (int i = 0; i < wx_q.size(); i++) begin
      n_checks++;
      if (wx_q[i] !== DW'(wbase + i)) begin
        n_bad++;
        $display("FAIL %s wdata[%0d] got=%h exp=%h", name, i, wx_q[i], DW'(wbase + i));
      end
    end
  endtask

  task automatic check_status(input string name, input logic [CW-1:0] exp);
    n_checks++;
    if (upendr !== exp) begin
      n_bad++;
      $display("FAIL %s upendr got=%h exp=%h", name, upendr, exp);
    end
  endtask

  task automatic test_reset();
    setup_env(0, 1000, 1'b0);
    #3;
    check_status("reset", 32'h0);
    n_checks++;
    if ({upsp_ac_rready, core_rvalid, core_wready, upsp_ac_wvalid} !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_gates got=%b exp=0000",
               {upsp_ac_rready, core_rvalid, core_wready, upsp_ac_wvalid});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) cycle(1'b0, '0);
    check_status("idle", 32'h0);
  endtask

  task automatic test_continuous();
    setup_env(0, 1000, 1'b1);
    run_frame("continuous", -1);
    check_status("continuous", 32'h1);
    check_data("continuous", RD_N, WR_N);
  endtask

  task automatic test_random_stalls();
    for (int f = 0; f < 3; f++) begin
      setup_env(40, 1000, 1'b1);
      run_frame("stalls", -1);
      check_status("stalls", 32'h1);
      check_data("stalls", RD_N, WR_N);
    end
  endtask

  task automatic test_error();
    setup_env(0, 5, 1'b0);
    run_frame("error", -1);
    check_status("error", 32'h4);
    check_data("error", 5, WR_N);
  endtask

  task automatic test_abort();
    setup_env(0, 3, 1'b1);
    run_frame("abort", 10);
    check_status("abort", 32'h8);
    n_checks++;
    if ({upsp_ac_rready, core_rvalid, core_wready, upsp_ac_wvalid} !== 4'b0000) begin
      n_bad++;
      $display("FAIL abort_gates got=%b exp=0000",
               {upsp_ac_rready, core_rvalid, core_wready, upsp_ac_wvalid});
    end
    check_data("abort", 3, -1);
    setup_env(0, 1000, 1'b1);
    run_frame("after_abort", -1);
    check_status("after_abort", 32'h1);
    check_data("after_abort", RD_N, WR_N);
  endtask

  task automatic test_reset_mid_drain();
    int c;
    setup_env(0, 1000, 1'b1);
    cycle(1'b1, 32'h1);
    for (c = 0; c < 200; c++) begin
      if (!m_active || m_reads == RD_N) break;
      cycle(1'b0, '0);
    end
    n_checks++;
    if (!(m_active && m_reads == RD_N)) begin
      n_bad++;
      $display("FAIL drain_reach active=%0d reads=%0d exp_reads=%0d", m_active, m_reads, RD_N);
    end
    #1;
    rst_n = 1'b0;
    #1;
    m_active = 0; m_done = 0; m_err = 0; m_aborted = 0; m_reads = 0; m_writes = 0;
    check_status("async_reset", 32'h0);
    n_checks++;
    if ({upsp_ac_rready, core_rvalid, core_wready, upsp_ac_wvalid} !== 4'b0000) begin
      n_bad++;
      $display("FAIL async_reset_gates got=%b exp=0000",
               {upsp_ac_rready, core_rvalid, core_wready, upsp_ac_wvalid});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    setup_env(0, 1000, 1'b1);
    run_frame("after_reset", -1);
    check_status("after_reset", 32'h1);
    check_data("after_reset", RD_N, WR_N);
  endtask

  initial begin
    rst_n          = 1'b0;
    crf_upstr_we   = 1'b0;
    crf_upstr      = '0;
    ac_upsp_rvalid = 1'b1;
    ac_upsp_rdata  = '0;
    core_rready    = 1'b1;
    core_wvalid    = 1'b1;
    core_wdata     = '0;
    ac_upsp_wready = 1'b1;
    m_active = 0; m_done = 0; m_err = 0; m_aborted = 0; m_reads = 0; m_writes = 0;
    test_reset();
    test_continuous();
    test_random_stalls();
    test_error();
    test_abort();
    test_reset_mid_drain();
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
